// File: rtl/mem_pkg.sv
// Shared definitions for the UART-addressed 16-bit register memory.
// Optional feature macro: MEM_RD_CHECKSUM_EN adds the checksum-byte states.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Command byte upper nibble; the lower nibble carries the word address.
    localparam logic [3:0] CMD_WR = 4'b0110;
    localparam logic [3:0] CMD_RD = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_SEND_HI,
        ST_HOLD_HI,
        ST_SEND_LO,
        ST_HOLD_LO
`ifdef MEM_RD_CHECKSUM_EN
        ,
        ST_SEND_CK,
        ST_HOLD_CK
`endif
    } rd_state_e;

endpackage

// File: rtl/mem_rd_resp_if.sv
// Signal bundle between the read responder and its environment
// (UART receiver, memory read port, UART transmitter).
interface mem_rd_resp_if;
    import mem_pkg::*;

    logic              data_rdy;
    logic [7:0]        data_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              busy;

    // Responder side.
    modport master (
        input  data_rdy, data_in, rd_data, tx_busy,
        output rd_en, rd_addr, tx_start, tx_data, busy
    );

    // Environment side.
    modport slave (
        output data_rdy, data_in, rd_data, tx_busy,
        input  rd_en, rd_addr, tx_start, tx_data, busy
    );

endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse in the first cycle a level is seen high.
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q;

    // Remember the previous level of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    // Combinational so the pulse is valid in the same cycle the level rises.
    assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/mem_rd_resp.sv
// UART-side read responder: accepts 0111aaaa commands, reads the addressed
// 16-bit word and transmits it high byte first.
// Optional feature macro: MEM_RD_CHECKSUM_EN appends a third byte hi^lo.
module mem_rd_resp #(
    parameter int RD_LAT = 1  // memory read latency, legal range 1..3
) (
    input logic          clk_in,
    input logic          reset,
    mem_rd_resp_if.master bus
);
    import mem_pkg::*;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

    rd_state_e         state_q;
    logic [1:0]        lat_cnt_q;
    logic [DATA_W-1:0] word_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              busy_q;
    logic              rdy_pulse;

    edge_detector u_rdy_edge (
        .clk     (clk_in),
        .rst_n   (reset),
        .sig_i   (bus.data_rdy),
        .pulse_o (rdy_pulse)
    );

    // Command FSM with read-latency counter and registered outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            word_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            // Strobes fall back low every cycle so they are single-cycle pulses.
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rdy_pulse && bus.data_in[7:4] == CMD_RD) begin
                        rd_addr_q <= {4'h0, bus.data_in[3:0]};
                        rd_en_q   <= 1'b1;
                        lat_cnt_q <= LAT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Data is sampled RD_LAT+1 edges after the accepting edge.
                    if (lat_cnt_q == 2'd0) begin
                        word_q  <= bus.rd_data;
                        state_q <= ST_SEND_HI;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                ST_SEND_HI: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= word_q[15:8];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_HOLD_HI;
                    end
                end
                // The transmitter raises tx_busy one cycle late; ignore it here.
                ST_HOLD_HI: state_q <= ST_SEND_LO;
                ST_SEND_LO: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= word_q[7:0];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_HOLD_LO;
                    end
                end
`ifdef MEM_RD_CHECKSUM_EN
                ST_HOLD_LO: state_q <= ST_SEND_CK;
                ST_SEND_CK: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= word_q[15:8] ^ word_q[7:0];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_HOLD_CK;
                    end
                end
                ST_HOLD_CK: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
`else
                ST_HOLD_LO: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_rd_resp.sv
// Self-checking bench for mem_rd_resp: memory and transmitter models,
// a vector table, hand-written corner sequences and a randomized phase.
// Optional feature macro: MEM_RD_CHECKSUM_EN (third byte hi^lo expected).
module tb_mem_rd_resp;

    localparam int RD_LAT = 1;
`ifdef MEM_RD_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] cmd;
        logic       exp_acc;
        logic [7:0] exp_addr;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;

    mem_rd_resp_if bus ();

    mem_rd_resp #(.RD_LAT(RD_LAT)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus.master)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- environment models ----------------
    logic [15:0] mem [16];
    logic [15:0] pipe [RD_LAT];
    int          busy_cyc = 10;
    int          busy_left = 0;
    logic        force_busy = 1'b0;
    int          cyc = 0;

    // Memory read port: data valid RD_LAT edges after the edge sampling rd_en.
    always @(posedge clk_in) begin
        pipe[0] <= bus.rd_en ? mem[bus.rd_addr[3:0]] : 16'h0BAD;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rd_data = pipe[RD_LAT-1];

    // Transmitter: busy for busy_cyc cycles starting the cycle after tx_start.
    always @(posedge clk_in) begin
        if (!reset)            busy_left <= 0;
        else if (bus.tx_start) busy_left <= busy_cyc;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign bus.tx_busy = force_busy || (busy_left > 0);

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor, sampling on the falling edge.
    ev_t  tx_q[$];
    ev_t  rd_q[$];
    int   wide_cnt = 0;
    logic prev_tx = 1'b0;
    logic prev_rd = 1'b0;
    always @(negedge clk_in) begin
        if (bus.tx_start) tx_q.push_back('{bus.tx_data, cyc});
        if (bus.rd_en)    rd_q.push_back('{bus.rd_addr, cyc});
        if (bus.tx_start && prev_tx) wide_cnt++;
        if (bus.rd_en && prev_rd)    wide_cnt++;
        prev_tx = bus.tx_start;
        prev_rd = bus.rd_en;
    end

    // ---------------- checking helpers ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_addr = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int t0);
        bus.data_in  = b;
        bus.data_rdy = 1'b1;
        t0 = cyc + 1;
        wait_cyc(2);
        bus.data_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        wait_cyc(RD_LAT + 4);
        for (int k = 0; k < 400; k++) begin
            if (!bus.busy && !bus.tx_busy) break;
            wait_cyc(1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " rd_en"},    bus.rd_en,    0);
        check({tag, " rd_addr"},  bus.rd_addr,  0);
        check({tag, " tx_start"}, bus.tx_start, 0);
        check({tag, " tx_data"},  bus.tx_data,  0);
        check({tag, " busy"},     bus.busy,     0);
    endtask

    // Compare one finished transaction against the expected word and timing.
    task automatic check_txn(input string name, input logic exp_acc, input logic [7:0] exp_addr,
                             input int t0, input bit chk_t);
        logic [15:0] w;
        logic [7:0]  eb [3];
        int          n_exp;
        n_exp = exp_acc ? NB : 0;
        check({name, " rd count"}, rd_q.size(), exp_acc ? 1 : 0);
        if (exp_acc) begin
            last_addr = exp_addr;
            if (rd_q.size() > 0) begin
                check({name, " rd addr"}, rd_q[0].b, exp_addr);
                if (chk_t) check({name, " rd time"}, rd_q[0].cyc, t0);
            end
        end
        w     = mem[exp_addr[3:0]];
        eb[0] = w[15:8];
        eb[1] = w[7:0];
        eb[2] = w[15:8] ^ w[7:0];
        check({name, " tx count"}, tx_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < tx_q.size(); i++) begin
            check($sformatf("%s byte%0d", name, i), tx_q[i].b, eb[i]);
            if (i == 0 && chk_t) check({name, " first tx time"}, tx_q[0].cyc, t0 + RD_LAT + 2);
            if (i > 0) check($sformatf("%s gap%0d", name, i), tx_q[i].cyc - tx_q[i-1].cyc, busy_cyc + 2);
        end
        check({name, " busy after"},    bus.busy,    0);
        check({name, " rd_addr held"},  bus.rd_addr, last_addr);
        check({name, " tx_start idle"}, bus.tx_start, 0);
        rd_q.delete();
        tx_q.delete();
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [11];

    initial begin
        int t0;
        int r;
        logic [7:0] cmd;

        vecs[0]  = '{8'h75, 1'b1, 8'h05};
        vecs[1]  = '{8'h63, 1'b0, 8'h00};
        vecs[2]  = '{8'h00, 1'b0, 8'h00};
        vecs[3]  = '{8'h73, 1'b1, 8'h03};
        vecs[4]  = '{8'h7F, 1'b1, 8'h0F};
        vecs[5]  = '{8'h6A, 1'b0, 8'h00};
        vecs[6]  = '{8'hF7, 1'b0, 8'h00};
        vecs[7]  = '{8'h70, 1'b1, 8'h00};
        vecs[8]  = '{8'h17, 1'b0, 8'h00};
        vecs[9]  = '{8'h77, 1'b1, 8'h07};
        vecs[10] = '{8'h7A, 1'b1, 8'h0A};

        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h1111) ^ 16'hA5C3;
        mem[5] = 16'hBEEF;
        mem[3] = 16'hBEEF;

        bus.data_rdy = 1'b0;
        bus.data_in  = 8'h00;

        // Reset values, while asserted and after release.
        #1;
        check_reset_vals("reset held");
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);
        check_reset_vals("after reset");

        // Vector table.
        for (int v = 0; v < 11; v++) begin
            send_byte(vecs[v].cmd, t0);
            wait_idle();
            check_txn($sformatf("vec%0d", v), vecs[v].exp_acc, vecs[v].exp_addr, t0, 1'b1);
        end

        // Command arriving while another is served is dropped.
        send_byte(8'h71, t0);
        wait_cyc(1);
        send_byte(8'h72, r);
        wait_idle();
        check_txn("drop", 1'b1, 8'h01, t0, 1'b1);

        // Transmitter held busy before the first byte.
        force_busy = 1'b1;
        send_byte(8'h75, t0);
        wait_cyc(100);
        check("forced no tx", tx_q.size(), 0);
        check("forced busy", bus.busy, 1);
        force_busy = 1'b0;
        r = cyc;
        wait_idle();
        if (tx_q.size() > 0) check("forced release time", tx_q[0].cyc, r + 1);
        check_txn("forced", 1'b1, 8'h05, t0, 1'b0);

        // Reset during HOLD_HI aborts the transaction.
        send_byte(8'h75, t0);
        for (int k = 0; k < 50; k++) begin
            if (tx_q.size() > 0) break;
            wait_cyc(1);
        end
        check("abort hi seen", tx_q.size(), 1);
        reset = 1'b0;
        #1;
        check_reset_vals("async reset");
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(40);
        check("abort no low byte", tx_q.size(), 1);
        check("abort no reread", rd_q.size(), 1);
        check("abort busy", bus.busy, 0);
        tx_q.delete();
        rd_q.delete();
        last_addr = 8'h00;

        // Randomized commands, memory contents and transmitter busy times.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            busy_cyc = $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 1) cmd = {4'h7, 4'($urandom_range(0, 15))};
            else                           cmd = 8'($urandom);
            send_byte(cmd, t0);
            wait_idle();
            check_txn($sformatf("rand%0d cmd%02h", it, cmd), cmd[7:4] == 4'h7,
                      {4'h0, cmd[3:0]}, t0, 1'b1);
        end

        check("pulse width violations", wide_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_rd_resp.md
# mem_rd_resp

UART-side read responder for the 16-bit register memory. Decodes read commands (`0111aaaa`) arriving from the UART receiver, fetches the addressed word through the memory read port, and returns it high byte first through the UART transmitter. It complements the write path in the same UART-addressed memory subsystem and uses the same 8-bit command byte format.

## Interface
Parameters:
- `RD_LAT`, default 1: memory read latency in cycles from the `rd_en` edge to a valid `rd_data`. Legal range is 1–3.

Ports:
- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `data_rdy`  in  1  UART receiver byte-ready level.
- `data_in`  in  8  UART receiver byte.
- `rd_en`  out  1  one-cycle memory read strobe.
- `rd_addr`  out  8  memory read address, zero-extended from the command nibble.
- `rd_data`  in  16  memory read data.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until the next `tx_start`.
- `tx_busy`  in  1  transmitter busy. Must be high in the cycle after `tx_start` and stay high until the byte is done.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rdy_pulse` is `data_rdy` AND NOT registered `data_rdy`. It is combinational, so it is valid in the first cycle `data_rdy` is sampled high.
- In IDLE, a `rdy_pulse` with `data_in[7:4]==4'b0111` accepts the command:
  - `rd_addr <= {4'h0, data_in[3:0]}`, `rd_en <= 1`, go to RD_WAIT.
- All other nibbles are ignored, including write commands (`0110`).
- Any `rdy_pulse` outside IDLE is dropped. Commands are not queued.
- States:
  - IDLE
  - RD_WAIT: counts `RD_LAT` cycles, then latches `rd_data` into `word`.
  - SEND_HI: waits for `tx_busy==0`, then `tx_data<=word[15:8]`, `tx_start<=1`.
  - HOLD_HI: one cycle in which `tx_busy` is ignored.
  - SEND_LO: waits for `tx_busy==0`, then sends `word[7:0]`.
  - HOLD_LO: one cycle, then go to IDLE (or SEND_CK when the checksum is enabled).
- `rd_en` and `tx_start` are strictly single-cycle pulses.
- `rd_addr` holds its value until the next accepted command.
- Reset values: `rd_en=0`, `rd_addr=0`, `tx_start=0`, `tx_data=0`, `busy=0`, state IDLE, `word=0`.
- Reset asserted mid-transaction aborts it immediately. No further bytes are sent after reset releases.

## Timing
- Edge E0, the accepting edge: `rd_en` is high after E0 and low after E1.
- `rd_data` is sampled at edge E0+`RD_LAT`+1.
- `tx_start` for the high byte is high after E0+`RD_LAT`+2, provided `tx_busy` is low.
- Minimum command-to-first-`tx_start` latency is `RD_LAT`+2 cycles.
- The low byte `tx_start` occurs at the first edge where `tx_busy` is low, no earlier than 2 cycles after the high-byte `tx_start`.
- If `tx_busy` is held high, the block waits indefinitely in SEND_x with `tx_start` low. There is no timeout.

## Configuration
- `MEM_RD_CHECKSUM_EN` defined:
  - Adds states SEND_CK and HOLD_CK.
  - A third byte `word[15:8]^word[7:0]` is sent after the low byte with the same handshake.
  - `busy` stays high through HOLD_CK.
- Undefined: exactly two bytes are sent per read, and the checksum states are absent.

## Structure
- Shared package `mem_pkg` holds:
  - command nibble constants `CMD_WR=4'b0110` and `CMD_RD=4'b0111`;
  - the state enum;
  - `ADDR_W=8` and `DATA_W=16`.
- Reuse the existing `edge_detector` sub-module for `rdy_pulse`.
- The rest is one FSM plus the `RD_LAT` down-counter.

## Test plan
- Read address 5 with mem[5]=0xBEEF, `RD_LAT=1`, `tx_busy` model of 10 cycles → expect:
  - `rd_en` high for 1 cycle with `rd_addr=0x05`;
  - `tx_start` with `tx_data=0xBE` 3 cycles after `rdy_pulse`;
  - then `tx_start` with `0xEF`;
  - `busy` low afterwards.
- Byte `0x63` (write) and byte `0x00` → no `rd_en`, no `tx_start`, `busy` stays 0.
- Command `0x72` sent while serving `0x71` → exactly 2 bytes sent, for address 1 only; `rd_addr` stays 0x01.
- `tx_busy` forced high for 100 cycles before the first byte → `tx_start` withheld, then exactly one pulse per byte.
- Reset pulled low during HOLD_HI → all outputs return to their reset values asynchronously; no low byte is ever sent.
- With `MEM_RD_CHECKSUM_EN` and mem[3]=0xBEEF → bytes 0xBE, 0xEF, 0x51 in that order.
